// File: rtl/aes_pkg.sv
// Shared AES-128 types, constants and GF(2^8) helpers used by the key expansion datapath.
package aes_pkg;

  localparam int          AES_KEY_W     = 128;
  localparam int          AES_NR        = 10;
  localparam logic [7:0]  AES_RCON_INIT = 8'h01;

  typedef logic [AES_KEY_W-1:0] aes_key_t;

  typedef enum logic [1:0] {
    KX_IDLE,
    KX_EXPAND,
    KX_READY
  } kx_state_e;

  function automatic logic [7:0] gf_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = 8'h00;
    aa  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ aa;
      aa = gf_xtime(aa);
    end
    return acc;
  endfunction

  // Multiplicative inverse as x^254 (0 maps to 0), followed by the AES affine transform.
  function automatic logic [7:0] aes_sbox(input logic [7:0] x);
    logic [7:0] x2, x3, x12, x15, x240, x252, inv;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
    x15  = gf_mul(x12, x3);
    x240 = gf_mul(x15, x15);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    x252 = gf_mul(x240, x12);
    inv  = gf_mul(x252, x2);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/aes_key_scheduling.sv
// Combinational single-round AES-128 key schedule step: next round key and next rcon.
module aes_key_scheduling
  import aes_pkg::*;
(
  input  aes_key_t   key_in,
  input  logic [7:0] rcon_in,
  output aes_key_t   key_next_out,
  output logic [7:0] key_rcon_out
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot_w, sub_w, temp_w;
  logic [31:0] n0, n1, n2, n3;

  assign w0 = key_in[127:96];
  assign w1 = key_in[95:64];
  assign w2 = key_in[63:32];
  assign w3 = key_in[31:0];

  assign rot_w = {w3[23:0], w3[31:24]};

  assign sub_w = {aes_sbox(rot_w[31:24]), aes_sbox(rot_w[23:16]),
                  aes_sbox(rot_w[15:8]),  aes_sbox(rot_w[7:0])};

  assign temp_w = sub_w ^ {rcon_in, 24'h000000};

  assign n0 = w0 ^ temp_w;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign key_next_out = {n0, n1, n2, n3};
  assign key_rcon_out = gf_xtime(rcon_in);

endmodule

// File: rtl/aes_key_expand.sv
// Sequential AES-128 key expansion: one round key per clock into an 11-entry register store,
// served through a registered random-access read port.
module aes_key_expand
  import aes_pkg::*;
#(
  parameter int         NUM_ROUNDS = AES_NR,
  parameter logic [7:0] RCON_INIT  = AES_RCON_INIT
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           key_valid_in,
  output logic           key_ready_out,
  input  logic [127:0]   key_in,
  input  logic           rk_rd_en_in,
  input  logic [3:0]     rk_idx_in,
  output logic [127:0]   rk_out,
  output logic           rk_valid_out,
  output logic           keys_ready_out,
  output logic           busy_out
);

  // state      | meaning
  // KX_IDLE    | no key loaded, waiting for a key
  // KX_EXPAND  | writing slot[cnt] each cycle from the schedule step
  // KX_READY   | all round keys stored, reads served, new key accepted
  localparam logic [3:0] LAST_CNT = 4'(NUM_ROUNDS);

  kx_state_e  state_q;
  logic [3:0] cnt_q;
  logic       key_ready_q;
  logic       keys_ready_q;
  logic       busy_q;

  aes_key_t   slot_q [0:NUM_ROUNDS];
  aes_key_t   wkey_q, wkey_d;
  logic [7:0] rcon_q, rcon_d;
  aes_key_t   rk_q;
  logic       rk_valid_q;

  aes_key_t   key_next;
  logic [7:0] rcon_next;

  logic       accept;
  logic       rd_ok;
  logic       slot_we;
  logic [3:0] slot_widx;

  aes_key_scheduling u_sched (
    .key_in       (wkey_q),
    .rcon_in      (rcon_q),
    .key_next_out (key_next),
    .key_rcon_out (rcon_next)
  );

  assign accept = key_valid_in && key_ready_q;
  assign rd_ok  = rk_rd_en_in && keys_ready_q && (rk_idx_in <= LAST_CNT);

  always_comb begin
    wkey_d    = wkey_q;
    rcon_d    = rcon_q;
    slot_we   = 1'b0;
    slot_widx = cnt_q;
    if (accept) begin
      wkey_d    = key_in;
      rcon_d    = RCON_INIT;
      slot_we   = 1'b1;
      slot_widx = 4'd0;
    end else if (state_q == KX_EXPAND) begin
      wkey_d    = key_next;
      rcon_d    = rcon_next;
      slot_we   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= KX_IDLE;
      cnt_q        <= 4'd0;
      key_ready_q  <= 1'b1;
      keys_ready_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        KX_IDLE: begin
          if (accept) begin
            state_q     <= KX_EXPAND;
            cnt_q       <= 4'd1;
            key_ready_q <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        KX_EXPAND: begin
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == LAST_CNT) begin
            state_q      <= KX_READY;
            key_ready_q  <= 1'b1;
            keys_ready_q <= 1'b1;
            busy_q       <= 1'b0;
          end
        end
        KX_READY: begin
          if (accept) begin
            state_q      <= KX_EXPAND;
            cnt_q        <= 4'd1;
            key_ready_q  <= 1'b0;
            keys_ready_q <= 1'b0;
            busy_q       <= 1'b1;
          end
        end
        default: begin
          state_q      <= KX_IDLE;
          cnt_q        <= 4'd0;
          key_ready_q  <= 1'b1;
          keys_ready_q <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  // Reads sample the store before this edge's write, so a read racing a new accept sees the old key.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= NUM_ROUNDS; i++) slot_q[i] <= '0;
      wkey_q     <= '0;
      rcon_q     <= RCON_INIT;
      rk_q       <= '0;
      rk_valid_q <= 1'b0;
    end else begin
      wkey_q     <= wkey_d;
      rcon_q     <= rcon_d;
      rk_valid_q <= rd_ok;
      if (slot_we) slot_q[slot_widx] <= wkey_d;
      if (rd_ok) rk_q <= slot_q[rk_idx_in];
    end
  end

  assign key_ready_out  = key_ready_q;
  assign keys_ready_out = keys_ready_q;
  assign busy_out       = busy_q;
  assign rk_out         = rk_q;
  assign rk_valid_out   = rk_valid_q;

endmodule

// File: tb/tb_aes_key_expand.sv
// Self-checking bench for aes_key_expand: FIPS-197 vectors, corner sequences and a random-key model.
module tb_aes_key_expand;

  logic         clk;
  logic         rst_n;
  logic         key_valid_in;
  logic         key_ready_out;
  logic [127:0] key_in;
  logic         rk_rd_en_in;
  logic [3:0]   rk_idx_in;
  logic [127:0] rk_out;
  logic         rk_valid_out;
  logic         keys_ready_out;
  logic         busy_out;

  int passed = 0;
  int total  = 0;

  logic [7:0]   sbox_t [256];
  logic [127:0] model_rk [11];

  localparam logic [127:0] KEY_A  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] RK10_A = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] exp;
  } rd_vec_t;

  rd_vec_t vecs [4];

  aes_key_expand dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .key_valid_in   (key_valid_in),
    .key_ready_out  (key_ready_out),
    .key_in         (key_in),
    .rk_rd_en_in    (rk_rd_en_in),
    .rk_idx_in      (rk_idx_in),
    .rk_out         (rk_out),
    .rk_valid_out   (rk_valid_out),
    .keys_ready_out (keys_ready_out),
    .busy_out       (busy_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  // S-box from the generator walk: p steps by x3, q by its inverse.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    for (int i = 0; i < 255; i++) begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sbox_t[p] = x ^ 8'h63;
    end
    sbox_t[0] = 8'h63;
  endtask

  task automatic model_expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc [10];
    rc = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
        t = t ^ {rc[i/4-1], 24'h0};
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Accept on the next rising edge; returns at the negedge after it.
  task automatic accept_key(input logic [127:0] k);
    key_valid_in = 1'b1;
    key_in       = k;
    step();
    key_valid_in = 1'b0;
  endtask

  task automatic wait_ready(output int busy_cycles);
    int n;
    busy_cycles = 0;
    n = 0;
    while (!keys_ready_out && n < 40) begin
      if (busy_out) busy_cycles++;
      step();
      n++;
    end
    if (!keys_ready_out) begin
      total++;
      $display("FAIL wait_ready timeout actual=0 required=1");
    end
  endtask

  task automatic read_idx(input logic [3:0] idx);
    rk_rd_en_in = 1'b1;
    rk_idx_in   = idx;
    step();
    rk_rd_en_in = 1'b0;
  endtask

  initial begin
    int bc;
    logic [127:0] held;
    logic [127:0] rk;
    logic [3:0]   ri;

    vecs[0] = '{4'd0,  KEY_A};
    vecs[1] = '{4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
    vecs[2] = '{4'd2,  128'hf2c295f27a96b9435935807a7359f67f};
    vecs[3] = '{4'd10, RK10_A};

    build_sbox();
    rst_n        = 1'b0;
    key_valid_in = 1'b0;
    key_in       = '0;
    rk_rd_en_in  = 1'b0;
    rk_idx_in    = '0;

    // 1. reset state
    step(); step();
    rst_n = 1'b1;
    step(); step();
    chk("rst key_ready",  128'(key_ready_out),  128'd1);
    chk("rst keys_ready", 128'(keys_ready_out), 128'd0);
    chk("rst busy",       128'(busy_out),       128'd0);
    chk("rst rk_valid",   128'(rk_valid_out),   128'd0);
    chk("rst rk_out",     rk_out,               128'd0);

    // 2. FIPS-197 key
    accept_key(KEY_A);
    chk("accept key_ready low", 128'(key_ready_out), 128'd0);
    wait_ready(bc);
    chk("expand busy cycles", 128'(bc), 128'd10);
    chk("ready key_ready", 128'(key_ready_out), 128'd1);
    foreach (vecs[i]) begin
      read_idx(vecs[i].idx);
      chk($sformatf("vec idx%0d valid", vecs[i].idx), 128'(rk_valid_out), 128'd1);
      chk($sformatf("vec idx%0d data", vecs[i].idx), rk_out, vecs[i].exp);
    end

    // back-to-back reads of every slot against the model
    model_expand(KEY_A);
    rk_rd_en_in = 1'b1;
    for (int i = 0; i < 11; i++) begin
      rk_idx_in = 4'(i);
      step();
      chk($sformatf("b2b idx%0d", i), {rk_out[126:0], rk_valid_out}, {model_rk[i][126:0], 1'b1});
    end
    rk_rd_en_in = 1'b0;

    // 3. key_valid during EXPAND is ignored
    accept_key(KEY_A);
    key_valid_in = 1'b1;
    key_in       = ~KEY_A;
    chk("expand key_ready low", 128'(key_ready_out), 128'd0);
    step(); step();
    key_valid_in = 1'b0;
    wait_ready(bc);
    read_idx(4'd10);
    chk("ignored key idx10", rk_out, RK10_A);

    // 4. out-of-range reads hold rk_out
    read_idx(4'd11);
    chk("idx11 valid", 128'(rk_valid_out), 128'd0);
    chk("idx11 hold",  rk_out, RK10_A);
    read_idx(4'd15);
    chk("idx15 valid", 128'(rk_valid_out), 128'd0);
    chk("idx15 hold",  rk_out, RK10_A);

    // read racing a zero-key accept sees the old key
    rk_rd_en_in  = 1'b1;
    rk_idx_in    = 4'd10;
    key_valid_in = 1'b1;
    key_in       = '0;
    step();
    rk_rd_en_in  = 1'b0;
    key_valid_in = 1'b0;
    chk("race rk_out",     rk_out, RK10_A);
    chk("race rk_valid",   128'(rk_valid_out),   128'd1);
    chk("race keys_ready", 128'(keys_ready_out), 128'd0);
    read_idx(4'd3);
    chk("notready valid", 128'(rk_valid_out), 128'd0);
    chk("notready hold",  rk_out, RK10_A);
    wait_ready(bc);
    model_expand('0);
    read_idx(4'd10);
    chk("zero key idx10", rk_out, model_rk[10]);

    // 5. async reset mid-expansion
    accept_key(KEY_A);
    step(); step(); step(); step();
    rst_n = 1'b0;
    #1;
    chk("midrst key_ready",  128'(key_ready_out),  128'd1);
    chk("midrst keys_ready", 128'(keys_ready_out), 128'd0);
    chk("midrst busy",       128'(busy_out),       128'd0);
    chk("midrst rk_valid",   128'(rk_valid_out),   128'd0);
    chk("midrst rk_out",     rk_out,               128'd0);
    step();
    rst_n = 1'b1;
    step();
    accept_key(KEY_A);
    wait_ready(bc);
    chk("reaccept busy cycles", 128'(bc), 128'd10);
    read_idx(4'd10);
    chk("reaccept idx10", rk_out, RK10_A);

    // random keys against the reference model
    for (int n = 0; n < 16; n++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      model_expand(rk);
      accept_key(rk);
      wait_ready(bc);
      chk($sformatf("rnd%0d busy cycles", n), 128'(bc), 128'd10);
      for (int j = 0; j < 3; j++) begin
        ri = 4'($urandom_range(0, 10));
        read_idx(ri);
        chk($sformatf("rnd%0d idx%0d", n, ri), {rk_out[126:0], rk_valid_out}, {model_rk[ri][126:0], 1'b1});
      end
      held = rk_out;
      read_idx(4'($urandom_range(11, 15)));
      chk($sformatf("rnd%0d bad idx", n), {rk_out[126:0], rk_valid_out}, {held[126:0], 1'b0});
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
